parking_slot_allocator: RTL and testbench

- Sequential owner of the 8-bit parking occupancy vector (bit i = 1 means slot i is occupied).
- Accepts car-entry requests, assigns the lowest-index free slot and drives an entry-gate pulse.
- Accepts car-exit events naming a slot and frees that slot.
- Publishes the occupancy vector plus registered parked/full/empty status to the display and counting logic downstream.

---
 rtl/parking_slot_allocator_pkg.sv | 10 +
 rtl/parking_slot_allocator_slot_priority_encoder.sv | 30 +++
 rtl/parking_slot_allocator.sv | 150 +++++++++++++++
 tb/tb_parking_slot_allocator.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/parking_slot_allocator_pkg.sv
// Shared constants and state encoding for the parking slot allocator.
package parking_slot_allocator_pkg;
  localparam int         NUM_SLOTS = 8;
  localparam logic [7:0] FULL_MASK = 8'hFF;

  typedef enum logic {
    IDLE = 1'b0,
    GATE = 1'b1
  } state_e;
endpackage

// File: rtl/parking_slot_allocator_slot_priority_encoder.sv
// Finds the lowest-index free (zero) bit of the occupancy vector.
module slot_priority_encoder
  import parking_slot_allocator_pkg::*;
(
  input  logic [7:0] vec_i,
  output logic       free_found_o,
  output logic [2:0] free_idx_o
);

  // Lowest zero bit wins; an all-ones vector reports no free slot.
  always_comb begin
    free_found_o = 1'b1;
    free_idx_o   = 3'd0;
    casez (vec_i)
      8'b???????0: free_idx_o = 3'd0;
      8'b??????01: free_idx_o = 3'd1;
      8'b?????011: free_idx_o = 3'd2;
      8'b????0111: free_idx_o = 3'd3;
      8'b???01111: free_idx_o = 3'd4;
      8'b??011111: free_idx_o = 3'd5;
      8'b?0111111: free_idx_o = 3'd6;
      8'b01111111: free_idx_o = 3'd7;
      default: begin
        free_found_o = 1'b0;
        free_idx_o   = 3'd0;
      end
    endcase
  end

endmodule

// File: rtl/parking_slot_allocator.sv
// Owns the parking occupancy vector: grants lowest free slot on entry,
// frees slots on exit, drives the entry gate and publishes status.
module parking_slot_allocator
  import parking_slot_allocator_pkg::*;
#(
  parameter int GATE_CYCLES = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       enter_req_i,
  input  logic       exit_req_i,
  input  logic [2:0] exit_slot_i,
  output logic       grant_valid_o,
  output logic [2:0] grant_slot_o,
  output logic       full_reject_o,
  output logic       exit_error_o,
  output logic       gate_open_o,
  output logic [7:0] capacity_o,
  output logic [3:0] parked_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam logic [3:0] GATE_LOAD = 4'(GATE_CYCLES);

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] c;
    c = 4'd0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      c = c + {3'b000, v[i]};
    end
    return c;
  endfunction

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] capacity_q, capacity_d;
  logic [3:0] parked_q, parked_d;
  logic       full_q, full_d;
  logic       empty_q, empty_d;
  logic       grant_valid_q, grant_valid_d;
  logic [2:0] grant_slot_q, grant_slot_d;
  logic       full_reject_q, full_reject_d;
  logic       exit_error_q, exit_error_d;
  logic       gate_open_q, gate_open_d;

  logic       exit_hit_s;
  logic [7:0] post_exit_s;
  logic       free_found_s;
  logic [2:0] free_idx_s;

  // A legal exit is applied before allocation so a freed slot can be reused at once.
  assign exit_hit_s  = exit_req_i & capacity_q[exit_slot_i];
  assign post_exit_s = exit_hit_s ? (capacity_q & ~(8'h01 << exit_slot_i)) : capacity_q;

  slot_priority_encoder u_enc (
    .vec_i        (post_exit_s),
    .free_found_o (free_found_s),
    .free_idx_o   (free_idx_s)
  );

  // Next-state, allocation and gate timing.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    capacity_d    = post_exit_s;
    grant_valid_d = 1'b0;
    grant_slot_d  = grant_slot_q;
    full_reject_d = 1'b0;
    gate_open_d   = gate_open_q;
    exit_error_d  = exit_req_i & ~capacity_q[exit_slot_i];
    case (state_q)
      IDLE: begin
        gate_open_d = 1'b0;
        if (enter_req_i) begin
          if (free_found_s) begin
            capacity_d    = post_exit_s | (8'h01 << free_idx_s);
            grant_valid_d = 1'b1;
            grant_slot_d  = free_idx_s;
            gate_open_d   = 1'b1;
            cnt_d         = GATE_LOAD;
            state_d       = GATE;
          end else begin
            full_reject_d = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      GATE: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          cnt_d       = 4'd0;
          gate_open_d = 1'b0;
          state_d     = IDLE;
        end else begin
          gate_open_d = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        cnt_d       = 4'd0;
        gate_open_d = 1'b0;
      end
    endcase
    parked_d = popcount8(capacity_d);
    full_d   = (capacity_d == FULL_MASK);
    empty_d  = (capacity_d == 8'h00);
  end

  // State and registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      cnt_q         <= 4'd0;
      capacity_q    <= 8'h00;
      parked_q      <= 4'd0;
      full_q        <= 1'b0;
      empty_q       <= 1'b1;
      grant_valid_q <= 1'b0;
      grant_slot_q  <= 3'd0;
      full_reject_q <= 1'b0;
      exit_error_q  <= 1'b0;
      gate_open_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      capacity_q    <= capacity_d;
      parked_q      <= parked_d;
      full_q        <= full_d;
      empty_q       <= empty_d;
      grant_valid_q <= grant_valid_d;
      grant_slot_q  <= grant_slot_d;
      full_reject_q <= full_reject_d;
      exit_error_q  <= exit_error_d;
      gate_open_q   <= gate_open_d;
    end
  end

  assign grant_valid_o = grant_valid_q;
  assign grant_slot_o  = grant_slot_q;
  assign full_reject_o = full_reject_q;
  assign exit_error_o  = exit_error_q;
  assign gate_open_o   = gate_open_q;
  assign capacity_o    = capacity_q;
  assign parked_o      = parked_q;
  assign full_o        = full_q;
  assign empty_o       = empty_q;

endmodule

// File: tb/tb_parking_slot_allocator.sv
// Scoreboard bench: a cycle model pushes the expected outputs per cycle,
// each scenario task pops and compares them after the clock edge.
module tb_parking_slot_allocator;

  localparam int GC = 4;

  typedef struct packed {
    logic       gv;
    logic [2:0] gs;
    logic       fr;
    logic       ee;
    logic       go;
    logic [7:0] cap;
    logic [3:0] pk;
    logic       full;
    logic       empty;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enter_req = 1'b0;
  logic       exit_req = 1'b0;
  logic [2:0] exit_slot = 3'd0;
  logic       grant_valid, full_reject, exit_error, gate_open, full, empty;
  logic [2:0] grant_slot;
  logic [7:0] capacity;
  logic [3:0] parked;

  int n_vec = 0;
  int n_mis = 0;

  obs_t sb[$];
  obs_t got, exp_o;

  logic [7:0] m_cap = 8'h00;
  int         m_left = 0;
  logic [2:0] m_gs = 3'd0;

  parking_slot_allocator #(.GATE_CYCLES(GC)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .enter_req_i   (enter_req),
    .exit_req_i    (exit_req),
    .exit_slot_i   (exit_slot),
    .grant_valid_o (grant_valid),
    .grant_slot_o  (grant_slot),
    .full_reject_o (full_reject),
    .exit_error_o  (exit_error),
    .gate_open_o   (gate_open),
    .capacity_o    (capacity),
    .parked_o      (parked),
    .full_o        (full),
    .empty_o       (empty)
  );

  always #5 clk = ~clk;

  function automatic obs_t observe();
    obs_t o;
    o.gv = grant_valid; o.gs = grant_slot; o.fr = full_reject; o.ee = exit_error;
    o.go = gate_open; o.cap = capacity; o.pk = parked; o.full = full; o.empty = empty;
    return o;
  endfunction

  // Drive one cycle, push the model's expectation, advance past the edge.
  task automatic drive(input logic r, input logic en, input logic ex, input logic [2:0] sl);
    obs_t e;
    logic [7:0] c;
    int idx;
    int cnt;
    rst = r; enter_req = en; exit_req = ex; exit_slot = sl;
    e = '0;
    if (r) begin
      m_cap = 8'h00; m_left = 0; m_gs = 3'd0;
    end else begin
      e.ee = ex && !m_cap[sl];
      c = m_cap;
      if (ex && m_cap[sl]) c[sl] = 1'b0;
      if (m_left == 0) begin
        if (en) begin
          idx = -1;
          for (int i = 7; i >= 0; i--) if (!c[i]) idx = i;
          if (idx >= 0) begin
            c[idx] = 1'b1; m_gs = 3'(idx); e.gv = 1'b1; m_left = GC;
          end else begin
            e.fr = 1'b1;
          end
        end
      end else begin
        m_left = m_left - 1;
      end
      m_cap = c;
    end
    cnt = 0;
    for (int i = 0; i < 8; i++) cnt += int'(m_cap[i]);
    e.gs = m_gs; e.go = (m_left > 0); e.cap = m_cap; e.pk = 4'(cnt);
    e.full = (m_cap == 8'hFF); e.empty = (m_cap == 8'h00);
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b1, 1'b1, 3'd2);
      got = observe(); exp_o = sb.pop_front(); n_vec++;
      if (got !== exp_o) begin n_mis++; $display("FAIL reset cyc=%0d got=%h exp=%h", i, got, exp_o); end
    end
    n_vec++;
    if ({capacity, parked, empty, full, gate_open} !== {8'h00, 4'd0, 1'b1, 1'b0, 1'b0}) begin
      n_mis++; $display("FAIL reset_vals got cap=%h pk=%0d empty=%b", capacity, parked, empty);
    end
  endtask

  task automatic test_single_grant();
    int opens;
    drive(1'b0, 1'b1, 1'b0, 3'd0);
    got = observe(); exp_o = sb.pop_front(); n_vec++;
    if (got !== exp_o) begin n_mis++; $display("FAIL single_grant got=%h exp=%h", got, exp_o); end
    n_vec++;
    if ({grant_valid, grant_slot, capacity, parked, empty} !== {1'b1, 3'd0, 8'h01, 4'd1, 1'b0}) begin
      n_mis++; $display("FAIL single_grant_vals gv=%b gs=%0d cap=%h", grant_valid, grant_slot, capacity);
    end
    opens = int'(gate_open);
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0, 1'b0, 3'd0);
      got = observe(); exp_o = sb.pop_front(); n_vec++;
      if (got !== exp_o) begin n_mis++; $display("FAIL gate_seq cyc=%0d got=%h exp=%h", i, got, exp_o); end
      opens += int'(gate_open);
    end
    n_vec++;
    if (opens !== GC) begin n_mis++; $display("FAIL gate_len got=%0d exp=%0d", opens, GC); end
  endtask

  task automatic test_back_to_back();
    int ngrant;
    int last;
    ngrant = 0; last = 0;
    drive(1'b1, 1'b0, 1'b0, 3'd0); void'(sb.pop_front());
    for (int i = 1; i <= 41; i++) begin
      drive(1'b0, 1'b1, 1'b0, 3'd0);
      got = observe(); exp_o = sb.pop_front(); n_vec++;
      if (got !== exp_o) begin n_mis++; $display("FAIL fill cyc=%0d got=%h exp=%h", i, got, exp_o); end
      if (grant_valid) begin
        n_vec++;
        if (grant_slot !== 3'(ngrant) || (ngrant > 0 && i - last != GC + 1)) begin
          n_mis++; $display("FAIL fill_grant slot=%0d exp=%0d gap=%0d", grant_slot, ngrant, i - last);
        end
        ngrant++; last = i;
      end
    end
    n_vec++;
    if ({ngrant, full_reject, capacity, parked, full} !== {32'd8, 1'b1, 8'hFF, 4'd8, 1'b1}) begin
      n_mis++; $display("FAIL full_reject grants=%0d fr=%b cap=%h", ngrant, full_reject, capacity);
    end
  endtask

  task automatic test_simul_full();
    drive(1'b0, 1'b1, 1'b1, 3'd5);
    got = observe(); exp_o = sb.pop_front(); n_vec++;
    if (got !== exp_o) begin n_mis++; $display("FAIL simul got=%h exp=%h", got, exp_o); end
    n_vec++;
    if ({grant_valid, grant_slot, capacity, parked, full_reject} !== {1'b1, 3'd5, 8'hFF, 4'd8, 1'b0}) begin
      n_mis++; $display("FAIL simul_vals gs=%0d cap=%h fr=%b", grant_slot, capacity, full_reject);
    end
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0, 1'b0, 3'd0);
      got = observe(); exp_o = sb.pop_front(); n_vec++;
      if (got !== exp_o) begin n_mis++; $display("FAIL simul_tail cyc=%0d got=%h exp=%h", i, got, exp_o); end
    end
  endtask

  task automatic test_exit_error();
    logic [2:0] slots [5] = '{3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0, 1'b1, slots[i]);
      got = observe(); exp_o = sb.pop_front(); n_vec++;
      if (got !== exp_o) begin n_mis++; $display("FAIL exits cyc=%0d got=%h exp=%h", i, got, exp_o); end
    end
    drive(1'b0, 1'b0, 1'b1, 3'd1);
    got = observe(); exp_o = sb.pop_front(); n_vec++;
    if (got !== exp_o) begin n_mis++; $display("FAIL exit_err got=%h exp=%h", got, exp_o); end
    n_vec++;
    if ({exit_error, capacity, parked} !== {1'b1, 8'h0D, 4'd3}) begin
      n_mis++; $display("FAIL exit_err_vals ee=%b cap=%h pk=%0d", exit_error, capacity, parked);
    end
    drive(1'b0, 1'b0, 1'b0, 3'd1);
    got = observe(); exp_o = sb.pop_front(); n_vec++;
    if (got !== exp_o) begin n_mis++; $display("FAIL exit_err_clear got=%h exp=%h", got, exp_o); end
  endtask

  task automatic test_exit_during_gate();
    logic seen;
    seen = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 3'd0); void'(sb.pop_front());
    for (int i = 1; i <= 11; i++) begin
      drive(1'b0, 1'b1, 1'b0, 3'd0);
      got = observe(); exp_o = sb.pop_front(); n_vec++;
      if (got !== exp_o) begin n_mis++; $display("FAIL gate_fill cyc=%0d got=%h exp=%h", i, got, exp_o); end
    end
    drive(1'b0, 1'b0, 1'b1, 3'd1);
    got = observe(); exp_o = sb.pop_front(); n_vec++;
    if (got !== exp_o) begin n_mis++; $display("FAIL gate_exit got=%h exp=%h", got, exp_o); end
    n_vec++;
    if ({capacity, parked, gate_open} !== {8'h05, 4'd2, 1'b1}) begin
      n_mis++; $display("FAIL gate_exit_vals cap=%h pk=%0d go=%b", capacity, parked, gate_open);
    end
    for (int i = 0; i < 8 && !seen; i++) begin
      drive(1'b0, 1'b1, 1'b0, 3'd0);
      got = observe(); exp_o = sb.pop_front(); n_vec++;
      if (got !== exp_o) begin n_mis++; $display("FAIL regrant cyc=%0d got=%h exp=%h", i, got, exp_o); end
      if (grant_valid) seen = 1'b1;
    end
    n_vec++;
    if ({seen, grant_slot, capacity} !== {1'b1, 3'd1, 8'h07}) begin
      n_mis++; $display("FAIL regrant_vals seen=%b gs=%0d cap=%h", seen, grant_slot, capacity);
    end
    drive(1'b0, 1'b0, 1'b0, 3'd0); void'(sb.pop_front());
  endtask

  task automatic test_reset_mid_gate();
    drive(1'b1, 1'b0, 1'b0, 3'd0); void'(sb.pop_front());
    for (int i = 1; i <= 6; i++) begin
      drive(1'b0, 1'b1, 1'b0, 3'd0);
      got = observe(); exp_o = sb.pop_front(); n_vec++;
      if (got !== exp_o) begin n_mis++; $display("FAIL rg_fill cyc=%0d got=%h exp=%h", i, got, exp_o); end
    end
    drive(1'b0, 1'b0, 1'b0, 3'd0);
    got = observe(); exp_o = sb.pop_front(); n_vec++;
    if (got !== exp_o) begin n_mis++; $display("FAIL rg_gate got=%h exp=%h", got, exp_o); end
    drive(1'b1, 1'b1, 1'b1, 3'd0);
    got = observe(); exp_o = sb.pop_front(); n_vec++;
    if (got !== exp_o) begin n_mis++; $display("FAIL rg_reset got=%h exp=%h", got, exp_o); end
    n_vec++;
    if ({grant_valid, grant_slot, full_reject, exit_error, gate_open, capacity, parked, full, empty}
        !== {1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1}) begin
      n_mis++; $display("FAIL rg_reset_vals go=%b cap=%h gs=%0d", gate_open, capacity, grant_slot);
    end
    drive(1'b0, 1'b1, 1'b0, 3'd0);
    got = observe(); exp_o = sb.pop_front(); n_vec++;
    if (got !== exp_o || grant_valid !== 1'b1) begin
      n_mis++; $display("FAIL rg_idle got=%h exp=%h", got, exp_o);
    end
    drive(1'b0, 1'b0, 1'b0, 3'd0); void'(sb.pop_front());
  endtask

  initial begin
    test_reset();
    test_single_grant();
    test_back_to_back();
    test_simul_full();
    test_exit_error();
    test_exit_during_gate();
    test_reset_mid_gate();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
